// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: decodes one address window into synchronised input
// channels, sticky change flags and output registers; other addresses go to RAM.
module mmio_bridge #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 12,
    parameter int                N_IN    = 4,
    parameter int                N_OUT   = 4,
    parameter logic [ADDR_W-1:0] IO_BASE = 12'hF00
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_wren,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    ram_wEn,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_dataIn,
    input  logic [DATA_W-1:0]       ram_dataOut,
    input  logic [N_IN*DATA_W-1:0]  io_in,
    output logic [N_OUT*DATA_W-1:0] io_out,
    output logic [N_OUT-1:0]        io_out_strobe,
    output logic                    io_event
);

    localparam logic [5:0] OFF_FLAGS = 6'h10;

    function automatic logic [DATA_W-1:0] flags_word(input logic [N_IN-1:0] f);
        logic [DATA_W-1:0] w;
        w = '0;
        w[N_IN-1:0] = f;
        return w;
    endfunction

    logic              in_window;
    logic [5:0]        off;
    logic              flags_rd;
    logic              out_wr;

    logic [DATA_W-1:0] s1 [N_IN];
    logic [DATA_W-1:0] s2 [N_IN];
    logic [DATA_W-1:0] s3 [N_IN];
    logic [N_IN-1:0]   chg;
    logic [N_IN-1:0]   flags;

    logic [DATA_W-1:0] io_word_p0;
    logic [DATA_W-1:0] io_word_p1;
    logic              io_vld_p1;

    assign in_window  = (cpu_addr[ADDR_W-1:6] == IO_BASE[ADDR_W-1:6]);
    assign off        = cpu_addr[5:0];
    assign flags_rd   = in_window && (off == OFF_FLAGS);
    assign out_wr     = cpu_wren && in_window && (off[5:4] == 2'b10);

    assign ram_wEn    = cpu_wren && !in_window;
    assign ram_addr   = cpu_addr;
    assign ram_dataIn = cpu_wdata;

    assign io_event   = |flags;

    always_comb begin
        chg = '0;
        for (int k = 0; k < N_IN; k++) begin
            chg[k] = (s2[k] != s3[k]);
        end
    end

    // Synchroniser, history and sticky flags; a same-edge set overrides the read clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_IN; k++) begin
                s1[k] <= '0;
                s2[k] <= '0;
                s3[k] <= '0;
            end
            flags <= '0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                s1[k] <= io_in[k*DATA_W +: DATA_W];
                s2[k] <= s1[k];
                s3[k] <= s2[k];
            end
            flags <= (flags_rd ? '0 : flags) | chg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out        <= '0;
            io_out_strobe <= '0;
        end else begin
            io_out_strobe <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                if (out_wr && (off[3:0] == 4'(j))) begin
                    io_out[j*DATA_W +: DATA_W] <= cpu_wdata;
                    io_out_strobe[j]           <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        io_word_p0 = '0;
        case (off[5:4])
            2'b00: begin
                for (int k = 0; k < N_IN; k++) begin
                    if (off[3:0] == 4'(k)) io_word_p0 = s2[k];
                end
            end
            2'b01: begin
                if (off[3:0] == 4'h0) io_word_p0 = flags_word(flags);
            end
            2'b10: begin
                for (int j = 0; j < N_OUT; j++) begin
                    if (off[3:0] == 4'(j)) io_word_p0 = io_out[j*DATA_W +: DATA_W];
                end
            end
            default: io_word_p0 = '0;
        endcase
    end

    // p0 -> p1: window hit and I/O word line up with the RAM's one-cycle read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_vld_p1  <= 1'b0;
            io_word_p1 <= '0;
        end else begin
            io_vld_p1  <= in_window;
            io_word_p1 <= io_word_p0;
        end
    end

    assign cpu_rdata = io_vld_p1 ? io_word_p1 : ram_dataOut;

endmodule
